// File: rtl/ldpc_syndrome_check.sv
// LDPC receive-side syndrome checker.
// Buffers a byte-serial codeword, accumulates syndrome = H * c^T one bit per
// cycle using an externally supplied H column, flags a zero syndrome, then
// replays the buffered bytes on request.
//
// Handshakes:
//   input  : a byte is taken on a rising edge where din_ready = 1 and en_din = 1
//            (din_ready is high only in LOAD, and en_start overrides it).
//   output : read_data is a level request; each edge that samples it high in
//            DONE/OUT issues one byte, which appears with en_out = 1 on the next
//            cycle. en_start always wins over en_din and read_data.
module ldpc_syndrome_check #(
    parameter int N_BYTES = 256,
    parameter int M       = 1024,
    parameter int AW      = $clog2(8 * N_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_start,
    input  logic          en_din,
    input  logic [7:0]    d_in,
    output logic          din_ready,
    output logic [AW-1:0] h_addr,
    input  logic [M-1:0]  h_col,
    input  logic          read_data,
    output logic          done_check,
    output logic          syndrome_ok,
    output logic [M-1:0]  syndrome,
    output logic          en_out,
    output logic [7:0]    d_out,
    output logic [2:0]    state_dbg
);

    // Byte index width; h_addr is {byte index, bit index}. Needs N_BYTES >= 2.
    localparam int BW = AW - 3;
    localparam logic [BW-1:0] LAST_BYTE = BW'(N_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ACC  = 3'd2,
        S_DONE = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    byte_buf [N_BYTES];
    logic [7:0]    shift_reg;
    logic [BW-1:0] byte_cnt;
    logic [BW-1:0] rd_cnt;
    logic [2:0]    bit_cnt;
    logic          accept;
    logic          issue;
    logic          cur_bit;

    assign accept  = (state == S_LOAD) && en_din && !en_start;
    assign issue   = ((state == S_DONE) || (state == S_OUT)) && read_data && !en_start;
    assign cur_bit = shift_reg[3'd7 - bit_cnt];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; en_start restarts the frame from any state.
    always_comb begin
        state_nxt = state;
        if (en_start) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_IDLE;
                S_LOAD: if (en_din) state_nxt = S_ACC;
                S_ACC: begin
                    if (bit_cnt == 3'd7)
                        state_nxt = (byte_cnt == LAST_BYTE) ? S_DONE : S_LOAD;
                end
                S_DONE: begin
                    if (read_data)
                        state_nxt = (rd_cnt == LAST_BYTE) ? S_IDLE : S_OUT;
                end
                S_OUT: begin
                    if (read_data && (rd_cnt == LAST_BYTE)) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        din_ready   = 1'b0;
        h_addr      = '0;
        done_check  = 1'b0;
        syndrome_ok = 1'b0;
        state_dbg   = state;
        case (state)
            S_LOAD: din_ready = 1'b1;
            S_ACC:  h_addr = {byte_cnt, bit_cnt};
            S_DONE, S_OUT: begin
                done_check  = 1'b1;
                syndrome_ok = (syndrome == '0);
            end
            default: ;
        endcase
    end

    // Codeword buffer; contents are only meaningful for the current frame.
    always_ff @(posedge clk) begin
        if (accept) byte_buf[byte_cnt] <= d_in;
    end

    // Counters, syndrome accumulation and replay register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syndrome  <= '0;
            shift_reg <= '0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            rd_cnt    <= '0;
            en_out    <= 1'b0;
            d_out     <= '0;
        end else begin
            en_out <= 1'b0;
            if (en_start) begin
                syndrome <= '0;
                byte_cnt <= '0;
                bit_cnt  <= '0;
                rd_cnt   <= '0;
            end else begin
                if (accept) begin
                    shift_reg <= d_in;
                    bit_cnt   <= '0;
                end
                if (state == S_ACC) begin
                    if (cur_bit) syndrome <= syndrome ^ h_col;
                    bit_cnt <= bit_cnt + 3'd1;
                    if ((bit_cnt == 3'd7) && (byte_cnt != LAST_BYTE))
                        byte_cnt <= byte_cnt + BW'(1);
                end
                if (issue) begin
                    d_out  <= byte_buf[rd_cnt];
                    en_out <= 1'b1;
                    rd_cnt <= rd_cnt + BW'(1);
                end
            end
        end
    end

endmodule
